// File: rtl/ddr_package.sv
// rtl/ddr_package.sv - shared types and constants for the CAS issue scheduler
package ddr_package;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] READ    = 2'b01;
    localparam logic [1:0] WRITE   = 2'b10;

    // Timer field width of a queued request; the scheduler's CNT_W defaults to it.
    localparam int CAS_CNT_W = 6;

    typedef enum logic [2:0] {
        CAS_IDLE       = 3'd0,
        CAS_WAIT_STATE = 3'd1,
        CAS_WAIT_DATA  = 3'd2,
        CAS_WAIT_EXTRA = 3'd3,
        CAS_CMD        = 3'd4
    } cas_fsm_type;

    typedef struct packed {
        logic [1:0]           rw;
        logic [CAS_CNT_W-1:0] timer;
    } cas_req_t;

    function automatic logic legal_rw(input logic [1:0] code);
        return (code == READ) || (code == WRITE);
    endfunction

endpackage

// File: rtl/cas_req_fifo.sv
// rtl/cas_req_fifo.sv - circular request queue whose entry timers count down to 0 every cycle
module cas_req_fifo
    import ddr_package::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic                     push_i,
    input  cas_req_t                 push_data_i,
    input  logic                     pop_i,
    output cas_req_t                 head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    cas_req_t        mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    // count never exceeds DEPTH (a power of two), so the MSB alone marks full
    assign full_o  = count_q[AW];
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // Stale slots also count down; harmless since a push overwrites the whole entry.
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].timer != '0) begin
                    mem_q[i].timer <= mem_q[i].timer - CAS_CNT_W'(1);
                end
            end
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cas_scheduler.sv
// rtl/cas_scheduler.sv - CAS issue scheduler enforcing tRCD, tCCD and read/write turnaround
// CAS_STATS_EN adds rd_cnt/wr_cnt/turn_cnt statistics outputs.
module cas_scheduler
    import ddr_package::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = CAS_CNT_W,
    parameter int TCCD  = 4
) (
    input  logic             clock_t,
    input  logic             reset_n,
    input  logic             act_rdy,
    input  logic [1:0]       rw_request,
    input  logic [CNT_W-1:0] trcd,
    input  logic [CNT_W-1:0] rtw_gap,
    input  logic [CNT_W-1:0] wtr_gap,
    input  logic             rw_done,
    output logic             cas_rdy,
    output logic [1:0]       rw,
    output logic             cas_idle,
    output logic             q_full,
    output logic             err
`ifdef CAS_STATS_EN
    ,
    output logic [15:0]      rd_cnt,
    output logic [15:0]      wr_cnt,
    output logic [15:0]      turn_cnt
`endif
);

    localparam int AW      = $clog2(DEPTH);
    // CMD plus the following WAIT_STATE cycle already account for two cycles of spacing.
    localparam int TCCD_RL = (TCCD >= 2) ? TCCD - 2 : 0;

    cas_fsm_type      state_q, state_d;
    logic [1:0]       rw_q;
    logic             done_seen_q;
    logic [CNT_W-1:0] tccd_q;
    logic [CNT_W-1:0] gap_q;
    logic             err_q;

    cas_req_t         push_data;
    cas_req_t         head;
    logic             push_legal;
    logic             pop;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             head_ready;
    logic             same_dir;
    logic             enter_extra;
    logic             enter_cmd;
    logic [CNT_W-1:0] gap_sel;

    assign push_legal = act_rdy && legal_rw(rw_request);
    assign pop        = (state_q == CAS_CMD);

    always_comb begin
        push_data       = '0;
        push_data.rw    = rw_request;
        push_data.timer = (trcd < CNT_W'(2)) ? CAS_CNT_W'(1) : CAS_CNT_W'(trcd - CNT_W'(1));
    end

    cas_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clock_t),
        .resetn_i    (reset_n),
        .push_i      (push_legal),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (count)
    );

    assign head_ready = (head.timer == '0) && (tccd_q == '0);
    assign same_dir   = (rw_q == RW_NONE) || (head.rw == rw_q);
    assign gap_sel    = (head.rw == WRITE) ? rtw_gap : wtr_gap;

    // WAIT_DATA watches done_seen_q rather than the raw pulse, so a pulse landing on the
    // same edge that WAIT_STATE picks WAIT_DATA is still honoured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAS_IDLE: begin
                if (!empty) state_d = CAS_WAIT_STATE;
            end
            CAS_WAIT_STATE: begin
                if (head_ready) begin
                    if (same_dir)         state_d = CAS_CMD;
                    else if (done_seen_q) state_d = CAS_WAIT_EXTRA;
                    else                  state_d = CAS_WAIT_DATA;
                end
            end
            CAS_WAIT_DATA: begin
                if (done_seen_q) state_d = CAS_WAIT_EXTRA;
            end
            CAS_WAIT_EXTRA: begin
                if (gap_q == '0) state_d = CAS_CMD;
            end
            CAS_CMD: begin
                state_d = (count[AW:1] != '0 || push_legal) ? CAS_WAIT_STATE : CAS_IDLE;
            end
            default: state_d = CAS_IDLE;
        endcase
    end

    assign enter_extra = (state_q != CAS_WAIT_EXTRA) && (state_d == CAS_WAIT_EXTRA);
    assign enter_cmd   = (state_q != CAS_CMD) && (state_d == CAS_CMD);

    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            state_q     <= CAS_IDLE;
            rw_q        <= RW_NONE;
            done_seen_q <= 1'b0;
            tccd_q      <= '0;
            gap_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= act_rdy && (!legal_rw(rw_request) || (full && !pop));

            // rw_q doubles as prev_rw; loading it on CMD entry makes rw valid during the strobe.
            if (enter_cmd) rw_q <= head.rw;

            if (pop)          done_seen_q <= 1'b0;
            else if (rw_done) done_seen_q <= 1'b1;

            if (pop)                  tccd_q <= CNT_W'(TCCD_RL);
            else if (tccd_q != '0)    tccd_q <= tccd_q - CNT_W'(1);

            if (enter_extra)                                    gap_q <= gap_sel;
            else if (state_q == CAS_WAIT_EXTRA && gap_q != '0)  gap_q <= gap_q - CNT_W'(1);
        end
    end

    assign cas_rdy  = (state_q == CAS_CMD);
    assign rw       = rw_q;
    assign cas_idle = empty && (state_q == CAS_IDLE);
    assign q_full   = full;
    assign err      = err_q;

`ifdef CAS_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, turn_cnt_q;

    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            turn_cnt_q <= '0;
        end else begin
            if (pop && rw_q == READ)  rd_cnt_q   <= rd_cnt_q + 16'd1;
            if (pop && rw_q == WRITE) wr_cnt_q   <= wr_cnt_q + 16'd1;
            if (enter_extra)          turn_cnt_q <= turn_cnt_q + 16'd1;
        end
    end

    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign turn_cnt = turn_cnt_q;
`endif

endmodule

// File: tb/tb_cas_scheduler.sv
// tb/tb_cas_scheduler.sv - scoreboard bench for cas_scheduler (CAS_STATS_EN optional)
module tb_cas_scheduler;
    import ddr_package::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 6;
    localparam int TCCD  = 4;

    logic             clock_t    = 1'b0;
    logic             reset_n    = 1'b0;
    logic             act_rdy    = 1'b0;
    logic [1:0]       rw_request = 2'b00;
    logic [CNT_W-1:0] trcd       = '0;
    logic [CNT_W-1:0] rtw_gap    = '0;
    logic [CNT_W-1:0] wtr_gap    = '0;
    logic             rw_done    = 1'b0;
    logic             cas_rdy;
    logic [1:0]       rw;
    logic             cas_idle;
    logic             q_full;
    logic             err;
`ifdef CAS_STATS_EN
    logic [15:0]      rd_cnt, wr_cnt, turn_cnt;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] rw;
    } exp_t;

    exp_t sb_q[$];
    int   err_exp[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    cas_scheduler #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .TCCD (TCCD)
    ) dut (
        .clock_t    (clock_t),
        .reset_n    (reset_n),
        .act_rdy    (act_rdy),
        .rw_request (rw_request),
        .trcd       (trcd),
        .rtw_gap    (rtw_gap),
        .wtr_gap    (wtr_gap),
        .rw_done    (rw_done),
        .cas_rdy    (cas_rdy),
        .rw         (rw),
        .cas_idle   (cas_idle),
        .q_full     (q_full),
        .err        (err)
`ifdef CAS_STATS_EN
        ,
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .turn_cnt   (turn_cnt)
`endif
    );

    always #5 clock_t = ~clock_t;
    always @(posedge clock_t) cyc <= cyc + 1;

    // Monitor: every strobe / err pulse is matched against the head of its queue.
    always @(negedge clock_t) begin
        exp_t e;
        int   c;
        if (cas_rdy) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL strobe: unexpected at cycle %0d rw %b", cyc, rw);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || e.rw !== rw) begin
                    n_bad++;
                    $display("FAIL strobe: got cycle %0d rw %b, expected cycle %0d rw %b",
                             cyc, rw, e.cyc, e.rw);
                end
            end
        end
        if (err) begin
            n_vec++;
            if (err_exp.size() == 0) begin
                n_bad++;
                $display("FAIL err: unexpected pulse at cycle %0d", cyc);
            end else begin
                c = err_exp.pop_front();
                if (c != cyc) begin
                    n_bad++;
                    $display("FAIL err: got pulse at cycle %0d, expected cycle %0d", cyc, c);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock_t);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_cas(input int c, input logic [1:0] r);
        exp_t e;
        e.cyc = c;
        e.rw  = r;
        sb_q.push_back(e);
    endtask

    task automatic push_req(input logic [1:0] code, output int k);
        act_rdy    = 1'b1;
        rw_request = code;
        tick();
        k          = cyc;
        act_rdy    = 1'b0;
        rw_request = 2'b00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cas_rdy"},  32'(cas_rdy),  0);
        check({tag, "_rw"},       32'(rw),       0);
        check({tag, "_cas_idle"}, 32'(cas_idle), 1);
        check({tag, "_q_full"},   32'(q_full),   0);
        check({tag, "_err"},      32'(err),      0);
    endtask

    initial begin
        int k;
        int d;

        // Reset state
        tick(2);
        check_reset_vals("reset");
        reset_n = 1'b1;
        tick(2);

        // Single READ, trcd=5: strobe at k+5, idle again at k+6
        trcd = 6'd5;
        push_req(READ, k);
        check("idle_after_push", 32'(cas_idle), 0);
        expect_cas(k + 5, READ);
        wait_until(k + 6);
        check("idle_after_read", 32'(cas_idle), 1);
        check("rw_held_read", 32'(rw), 32'(READ));
        tick(3);

        // trcd below 2 is treated as 2
        do_reset();
        trcd = 6'd0;
        push_req(WRITE, k);
        expect_cas(k + 2, WRITE);
        wait_until(k + 6);

        // Four back-to-back READs, trcd=3, TCCD=4: strobes at k+3, k+7, k+11, k+15
        do_reset();
        trcd = 6'd3;
        for (int i = 0; i < 4; i++) begin
            act_rdy    = 1'b1;
            rw_request = READ;
            tick();
            if (i == 0) k = cyc;
        end
        act_rdy    = 1'b0;
        rw_request = 2'b00;
        for (int i = 0; i < 4; i++) expect_cas(k + 3 + 4 * i, READ);
        wait_until(k + 20);

        // READ then WRITE, rtw_gap=3, rw_done at edge d: WRITE strobe at d+5
        do_reset();
        trcd    = 6'd3;
        rtw_gap = 6'd3;
        push_req(READ, k);
        push_req(WRITE, d);
        expect_cas(k + 3, READ);
        wait_until(k + 9);
        rw_done = 1'b1;
        tick();
        d       = cyc;
        rw_done = 1'b0;
        expect_cas(d + 5, WRITE);
        wait_until(d + 8);
        check("rw_held_write", 32'(rw), 32'(WRITE));
`ifdef CAS_STATS_EN
        check("turn_cnt_rtw", 32'(turn_cnt), 1);
        check("wr_cnt_rtw", 32'(wr_cnt), 1);
`endif

        // WRITE then READ, rw_done before READ timer expires, wtr_gap=0
        do_reset();
        wtr_gap = 6'd0;
        trcd    = 6'd2;
        push_req(WRITE, k);
        trcd    = 6'd10;
        push_req(READ, d);
        expect_cas(k + 2, WRITE);
        wait_until(k + 4);
        rw_done = 1'b1;
        tick();
        rw_done = 1'b0;
        // READ timer reaches 0 after edge k+10; strobe two cycles later
        expect_cas(k + 12, READ);
        wait_until(k + 16);
`ifdef CAS_STATS_EN
        check("turn_cnt_wtr", 32'(turn_cnt), 1);
`endif

        // Illegal codes: err pulse, nothing enqueued
        do_reset();
        push_req(2'b11, k);
        err_exp.push_back(k);
        check("illegal11_no_enqueue", 32'(cas_idle), 1);
        push_req(2'b00, k);
        err_exp.push_back(k);
        tick();
        check("illegal00_no_enqueue", 32'(cas_idle), 1);

        // Nine pushes into DEPTH=8: ninth dropped with err, q_full set
        trcd = 6'd40;
        for (int i = 0; i < 9; i++) begin
            act_rdy    = 1'b1;
            rw_request = READ;
            tick();
            if (i == 0) begin
                k = cyc;
                err_exp.push_back(k + 8);
            end
            if (i == 6) check("q_full_at_7", 32'(q_full), 0);
            if (i == 7) check("q_full_at_8", 32'(q_full), 1);
        end
        act_rdy    = 1'b0;
        rw_request = 2'b00;
        tick();
        check("q_full_after_drop", 32'(q_full), 1);
        check("err_one_cycle", 32'(err), 0);
        tick(2);

        // Reset low for one edge with three requests pending: no further strobes
        do_reset();
        trcd = 6'd20;
        for (int i = 0; i < 3; i++) push_req(READ, k);
        tick(5);
        check("pending_not_idle", 32'(cas_idle), 0);
        do_reset();
        check_reset_vals("midreset");
        tick(40);
        check("midreset_still_idle", 32'(cas_idle), 1);
`ifdef CAS_STATS_EN
        check("midreset_rd_cnt", 32'(rd_cnt), 0);
`endif

        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL strobe: missing, expected cycle %0d rw %b", e.cyc, e.rw);
        end
        while (err_exp.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL err: missing pulse, expected cycle %0d", err_exp.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cas_scheduler.md
# cas_scheduler

Parametrised CAS issue scheduler between the ACT sequencer and the burst-data block. Queues read/write requests at ACT time, enforces tRCD per request, tCCD between CAS commands and read/write turnaround (wait for burst completion plus a programmable gap). Emits a one-cycle `cas_rdy` strobe with direction `rw`. Unlike the previous CAS FSM, it holds a configurable number of pending requests and takes all timings as runtime inputs.

## Interface
- `DEPTH`, 8, pending-request queue entries (power of two, ≥2)
- `CNT_W`, 6, width of timing inputs and internal counters
- `TCCD`, 4, minimum cycles between consecutive `cas_rdy` strobes (≥1)
- `clock_t`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `act_rdy`  in  1  ACT issued this cycle; enqueue `rw_request`
- `rw_request`  in  2  READ=2'b01, WRITE=2'b10; other codes illegal
- `trcd`  in  CNT_W  ACT-to-CAS cycles; values <2 treated as 2
- `rtw_gap`  in  CNT_W  extra cycles after `rw_done` for READ→WRITE
- `wtr_gap`  in  CNT_W  extra cycles after `rw_done` for WRITE→READ
- `rw_done`  in  1  one-cycle pulse: current data burst finished
- `cas_rdy`  out  1  one-cycle CAS issue strobe
- `rw`  out  2  direction of issued CAS; held until next strobe
- `cas_idle`  out  1  queue empty and FSM in CAS_IDLE
- `q_full`  out  1  queue holds DEPTH entries
- `err`  out  1  one-cycle pulse: dropped (full) or illegal request

## Operation
- Entry = {rw, timer}. Push on `act_rdy` with legal code and queue not full: timer = max(trcd,2)−1. Every cycle each valid timer decrements, saturating at 0.
- Illegal code or push while full with no pop: entry dropped, `err`=1 next cycle. Push and pop in same cycle at full: accepted.
- FSM states (enum in package): CAS_IDLE, CAS_WAIT_STATE, CAS_WAIT_DATA, CAS_WAIT_EXTRA, CAS_CMD.
- CAS_IDLE → CAS_WAIT_STATE when queue non-empty.
- CAS_WAIT_STATE: wait for head timer==0 and tCCD counter expired. Then: same direction as `prev_rw` or no CAS since reset → CAS_CMD; else `done_seen` set → CAS_WAIT_EXTRA; else → CAS_WAIT_DATA.
- CAS_WAIT_DATA: on `rw_done` → CAS_WAIT_EXTRA.
- CAS_WAIT_EXTRA: count gap (`rtw_gap` for READ→WRITE, `wtr_gap` for WRITE→READ), sampled on entry; gap 0 → CAS_CMD next cycle.
- CAS_CMD (one cycle): `cas_rdy`=1, `rw`=head rw, pop head, `prev_rw`=head rw, clear `done_seen`, reload tCCD counter; → CAS_WAIT_STATE if queue still non-empty, else CAS_IDLE.
- `done_seen` set by any `rw_done` since last CAS; cleared at CAS_CMD.
- Counters never wrap: timers saturate at 0, gap/tCCD counters stop at terminal value.

## Timing
- Reset (sampled low at edge): queue flushed, FSM CAS_IDLE, `cas_rdy`=0, `rw`=2'b00, `cas_idle`=1, `q_full`=0, `err`=0, `prev_rw` invalid, `done_seen`=0. Mid-operation reset drops all pending requests; no strobe emitted afterward.
- Empty queue, `act_rdy` at edge k, same direction: `cas_rdy` high in cycle k+max(trcd,2).
- Back-to-back same direction: strobe spacing = max(TCCD, tRCD-remaining).
- Turnaround: `rw_done` at edge d, gap g → `cas_rdy` in cycle d+g+2 (g counted after entering CAS_WAIT_EXTRA).
- `cas_idle` deasserts the cycle after the first accepted push.

## Configuration
- `CAS_STATS_EN`: adds outputs `rd_cnt`, `wr_cnt`, `turn_cnt` (16 bits each, wrapping, reset 0), incremented on READ strobe, WRITE strobe and each CAS_WAIT_EXTRA entry. Without it, ports and counters are absent; behaviour otherwise identical.

## Structure
- `ddr_package`: `cas_fsm_type`, READ/WRITE constants, `cas_req_t` struct {rw, timer}.
- Sub-module `cas_req_fifo`: DEPTH-entry circular queue with per-entry saturating timers, head peek, full/empty, push/pop.

## Test plan
- trcd=5, one READ at cycle 10 → single `cas_rdy` in cycle 15, `rw`=01, `cas_idle` back to 1 in cycle 16.
- Four READs, one per cycle from cycle 0, trcd=3, TCCD=4 → strobes in cycles 3, 7, 11, 15.
- READ then WRITE, rtw_gap=3, `rw_done` at cycle 20 → WRITE strobe in cycle 25; `turn_cnt`=1 when `CAS_STATS_EN`.
- WRITE then READ with `rw_done` arriving before the READ timer expires, wtr_gap=0 → READ strobe 2 cycles after timer expiry via CAS_WAIT_EXTRA.
- DEPTH=8: nine pushes with no pops → ninth dropped, `err` one cycle, `q_full`=1; rw_request=2'b11 → `err`, no enqueue.
- Reset low for one edge while three requests pending → no further strobes, all outputs at reset values.
